// File: rtl/trap_arbiter_pkg.sv
// Shared types and constants for the trap arbiter: ROB index, trap payload,
// FSM state encoding, mtvec modes and interrupt priority order.
package trap_arbiter_pkg;

  localparam int unsigned ROB_SIZE = 64;
  localparam int unsigned ROB_W    = $clog2(ROB_SIZE);
  localparam int unsigned XDEF     = 64;
  localparam int unsigned CAUSE_W  = 6;

  typedef logic [ROB_W-1:0] robIdx_t;

  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic [XDEF-1:0]    epc;
    logic [XDEF-1:0]    tval;
  } trapInfo_t;

  typedef struct packed {
    trapInfo_t       info;
    logic            is_irq;
    logic [XDEF-1:0] target;
  } rv_trap_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    FIRE = 2'd2
  } trapArbState_e;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Highest priority first; causes not listed here never raise a trap.
  localparam int         IRQ_PRIO_N = 6;
  localparam logic [3:0] IRQ_PRIO [IRQ_PRIO_N] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  // Distance from the ROB head; relies on ROB_SIZE being a power of two.
  function automatic robIdx_t rob_age(input robIdx_t idx, input robIdx_t head);
    return idx - head;
  endfunction

  // Returns {found, cause} for the highest-priority pending interrupt.
  function automatic logic [4:0] irq_pick(input logic [15:0] pend);
    logic [4:0] r;
    r = '0;
    for (int i = IRQ_PRIO_N - 1; i >= 0; i--) begin
      if (pend[IRQ_PRIO[i]]) r = {1'b1, IRQ_PRIO[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/trap_arbiter_age_select.sv
// Combinational reducer: oldest valid report by ROB age, lowest channel on a tie.
module trap_age_select
  import trap_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  robIdx_t                 i_rob_head,
  input  logic [CHANNELS-1:0]     i_vld,
  input  robIdx_t [CHANNELS-1:0]  i_robIdx,
  output logic                    o_vld,
  output logic [IDX_W-1:0]        o_idx,
  output robIdx_t                 o_robIdx
);

  always_comb begin
    logic    found;
    robIdx_t best_age;
    found    = 1'b0;
    best_age = '0;
    o_idx    = '0;
    o_robIdx = '0;
    // Strict less-than keeps the earlier channel when ages are equal.
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_vld[i] && (!found || (rob_age(i_robIdx[i], i_rob_head) < best_age))) begin
        found    = 1'b1;
        best_age = rob_age(i_robIdx[i], i_rob_head);
        o_idx    = IDX_W'(i);
        o_robIdx = i_robIdx[i];
      end
    end
    o_vld = found;
  end

endmodule

// File: rtl/trap_arbiter.sv
// Keeps the oldest reported exception, blocks its retirement at the ROB head,
// merges interrupts at commit and issues one registered trap request.
//
// state | meaning
// IDLE  | no exception held
// HELD  | one exception stored, waiting for it to reach the head
// FIRE  | trap request presented, waiting for i_trap_rdy
module trap_arbiter
  import trap_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned XLEN     = XDEF,
  parameter bit          VEC_EN   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  robIdx_t                   i_rob_head,
  input  logic [CHANNELS-1:0]       i_exc_vld,
  input  robIdx_t [CHANNELS-1:0]    i_exc_robIdx,
  input  trapInfo_t [CHANNELS-1:0]  i_exc_info,
  input  logic                      i_flush,
  input  robIdx_t                   i_flush_robIdx,
  input  logic                      i_commit_vld,
  input  logic [XLEN-1:0]           i_commit_pc,
  output logic                      o_commit_block,
  input  logic [15:0]               i_irq_pend,
  input  logic                      i_irq_en,
  input  logic [XLEN-1:0]           i_mtvec,
  output logic                      o_trap_vld,
  input  logic                      i_trap_rdy,
  output trapInfo_t                 o_trap_info,
  output logic                      o_trap_is_irq,
  output logic [XLEN-1:0]           o_trap_target,
  output logic                      o_busy
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  trapArbState_e       state_q, state_d;
  robIdx_t             held_idx_q, held_idx_d;
  trapInfo_t           held_info_q, held_info_d;
  rv_trap_t            trap_q, trap_d;

  robIdx_t             flush_age;
  logic [CHANNELS-1:0] rep_vld;
  logic                sel_vld;
  logic [IDX_W-1:0]    sel_idx;
  robIdx_t             sel_robIdx;
  logic                held_at_head;
  logic                held_live;
  logic [4:0]          irq_sel;
  logic                irq_take;
  logic                exc_take;
  logic [XLEN-1:0]     mtvec_base;

  // Reports younger than the surviving flush point are dropped before selection.
  always_comb begin
    flush_age = rob_age(i_flush_robIdx, i_rob_head);
    rep_vld   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rep_vld[i] = i_exc_vld[i] &&
                   !(i_flush && (rob_age(i_exc_robIdx[i], i_rob_head) > flush_age));
    end
  end

  trap_age_select #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_age_select (
    .i_rob_head (i_rob_head),
    .i_vld      (rep_vld),
    .i_robIdx   (i_exc_robIdx),
    .o_vld      (sel_vld),
    .o_idx      (sel_idx),
    .o_robIdx   (sel_robIdx)
  );

  always_comb begin
    held_at_head = (state_q == HELD) && (held_idx_q == i_rob_head);
    held_live    = (state_q == HELD) &&
                   !(i_flush && (rob_age(held_idx_q, i_rob_head) > flush_age));
    irq_sel      = irq_pick(i_irq_pend);
    irq_take     = i_commit_vld && i_irq_en && irq_sel[4];
    exc_take     = i_commit_vld && held_at_head;
    mtvec_base   = {i_mtvec[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      held_idx_q  <= '0;
      held_info_q <= '0;
      trap_q      <= '0;
    end else begin
      state_q     <= state_d;
      held_idx_q  <= held_idx_d;
      held_info_q <= held_info_d;
      trap_q      <= trap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_idx_d  = held_idx_q;
    held_info_d = held_info_q;
    trap_d      = trap_q;
    unique case (state_q)
      IDLE, HELD: begin
        // An interrupt wins over a faulting head; the head re-executes later.
        if (irq_take) begin
          state_d          = FIRE;
          trap_d.info.cause = CAUSE_W'(irq_sel[3:0]);
          trap_d.info.epc  = i_commit_pc;
          trap_d.info.tval = '0;
          trap_d.is_irq    = 1'b1;
          trap_d.target    = (VEC_EN && (i_mtvec[1:0] == MTVEC_VECTORED)) ?
                             mtvec_base + XLEN'({irq_sel[3:0], 2'b00}) : mtvec_base;
        end else if (exc_take) begin
          state_d       = FIRE;
          trap_d.info   = held_info_q;
          trap_d.is_irq = 1'b0;
          trap_d.target = mtvec_base;
        end else if (sel_vld && (!held_live ||
                     (rob_age(sel_robIdx, i_rob_head) < rob_age(held_idx_q, i_rob_head)))) begin
          state_d     = HELD;
          held_idx_d  = sel_robIdx;
          held_info_d = i_exc_info[sel_idx];
        end else begin
          state_d = held_live ? HELD : IDLE;
        end
      end
      FIRE: begin
        if (i_trap_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_trap_vld     = (state_q == FIRE);
    o_busy         = (state_q != IDLE);
    o_commit_block = (state_q == FIRE) || held_at_head;
    o_trap_info    = trap_q.info;
    o_trap_is_irq  = trap_q.is_irq;
    o_trap_target  = trap_q.target;
  end

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed scenarios plus randomized traffic against
// an age-based reference model.
module tb_trap_arbiter;
  import trap_arbiter_pkg::*;

  localparam int CH = 4;
  localparam int RS = ROB_SIZE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  robIdx_t             rob_head;
  logic [CH-1:0]       exc_vld;
  robIdx_t [CH-1:0]    exc_robIdx;
  trapInfo_t [CH-1:0]  exc_info;
  logic                flush;
  robIdx_t             flush_robIdx;
  logic                commit_vld;
  logic [63:0]         commit_pc;
  logic                commit_block;
  logic [15:0]         irq_pend;
  logic                irq_en;
  logic [63:0]         mtvec;
  logic                trap_vld;
  logic                trap_rdy;
  trapInfo_t           trap_info;
  logic                trap_is_irq;
  logic [63:0]         trap_target;
  logic                busy;

  trap_arbiter #(.CHANNELS(CH), .XLEN(64), .VEC_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rob_head     (rob_head),
    .i_exc_vld      (exc_vld),
    .i_exc_robIdx   (exc_robIdx),
    .i_exc_info     (exc_info),
    .i_flush        (flush),
    .i_flush_robIdx (flush_robIdx),
    .i_commit_vld   (commit_vld),
    .i_commit_pc    (commit_pc),
    .o_commit_block (commit_block),
    .i_irq_pend     (irq_pend),
    .i_irq_en       (irq_en),
    .i_mtvec        (mtvec),
    .o_trap_vld     (trap_vld),
    .i_trap_rdy     (trap_rdy),
    .o_trap_info    (trap_info),
    .o_trap_is_irq  (trap_is_irq),
    .o_trap_target  (trap_target),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "firing" flag plus an optional oldest held exception.
  bit          m_fire   = 1'b0;
  bit          m_held_v = 1'b0;
  int          m_held_idx = 0;
  trapInfo_t   m_held_info = '0;
  trapInfo_t   m_trap_info = '0;
  bit          m_trap_irq  = 1'b0;
  logic [63:0] m_trap_target = '0;
  int          prio [6] = '{11, 3, 7, 9, 1, 5};

  function automatic int agef(input int x, input int h);
    return (x - h + RS) % RS;
  endfunction

  function automatic logic [63:0] exp_target(input bit irq, input int cause);
    logic [63:0] base;
    base = {mtvec[63:2], 2'b00};
    if (irq && mtvec[1:0] == 2'b01) return base + 64'(4 * cause);
    return base;
  endfunction

  task automatic model_step();
    int h, fa, irq_c;
    h     = rob_head;
    fa    = agef(flush_robIdx, h);
    irq_c = -1;
    if (m_fire) begin
      if (trap_rdy) begin
        m_fire   = 1'b0;
        m_held_v = 1'b0;
      end
    end else begin
      if (flush && m_held_v && agef(m_held_idx, h) > fa) m_held_v = 1'b0;
      if (irq_en) foreach (prio[k]) if (irq_c < 0 && irq_pend[prio[k]]) irq_c = prio[k];
      if (commit_vld && irq_c >= 0) begin
        m_fire            = 1'b1;
        m_held_v          = 1'b0;
        m_trap_info.cause = 6'(irq_c);
        m_trap_info.epc   = commit_pc;
        m_trap_info.tval  = '0;
        m_trap_irq        = 1'b1;
        m_trap_target     = exp_target(1'b1, irq_c);
      end else if (commit_vld && m_held_v && m_held_idx == h) begin
        m_fire        = 1'b1;
        m_held_v      = 1'b0;
        m_trap_info   = m_held_info;
        m_trap_irq    = 1'b0;
        m_trap_target = exp_target(1'b0, 0);
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (exc_vld[c] && !(flush && agef(exc_robIdx[c], h) > fa) &&
              (!m_held_v || agef(exc_robIdx[c], h) < agef(m_held_idx, h))) begin
            m_held_v    = 1'b1;
            m_held_idx  = exc_robIdx[c];
            m_held_info = exc_info[c];
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fire        = 1'b0;
      m_held_v      = 1'b0;
      m_trap_info   = '0;
      m_trap_irq    = 1'b0;
      m_trap_target = '0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("trap_vld", trap_vld, m_fire);
    chk("busy", busy, m_fire || m_held_v);
    chk("commit_block", commit_block, m_fire || (m_held_v && m_held_idx == rob_head));
    if (m_fire) begin
      chk("cause", trap_info.cause, m_trap_info.cause);
      chk("epc", trap_info.epc, m_trap_info.epc);
      chk("tval", trap_info.tval, m_trap_info.tval);
      chk("is_irq", trap_is_irq, m_trap_irq);
      chk("target", trap_target, m_trap_target);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    exc_vld    = '0;
    flush      = 1'b0;
    commit_vld = 1'b0;
    irq_pend   = '0;
    irq_en     = 1'b0;
    trap_rdy   = 1'b0;
  endtask

  task automatic report(input int ch, input int idx, input int cause);
    exc_vld[ch]         = 1'b1;
    exc_robIdx[ch]      = robIdx_t'(idx);
    exc_info[ch].cause  = 6'(cause);
    exc_info[ch].epc    = 64'h1000 + 64'(idx);
    exc_info[ch].tval   = 64'hBEEF_0000 + 64'(cause);
  endtask

  initial begin
    rob_head     = '0;
    exc_robIdx   = '0;
    exc_info     = '0;
    flush_robIdx = '0;
    commit_pc    = '0;
    mtvec        = 64'h8000_0000;
    idle_in();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trap_vld", trap_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_commit_block", commit_block, 0);
    chk("rst_is_irq", trap_is_irq, 0);
    chk("rst_cause", trap_info.cause, 0);
    chk("rst_target", trap_target, 0);
    rst = 1'b1;
    cyc();

    // Wrap-around: head=60, robIdx 62 (age 2) beats robIdx 2 (age 6).
    rob_head = 6'd60;
    report(0, 2, 2);
    report(1, 62, 13);
    cyc(); idle_in();
    chk("d1_busy", busy, 1);
    rob_head = 6'd62;
    commit_vld = 1'b1;
    #1 chk("d1_block", commit_block, 1);
    cyc(); idle_in();
    chk("d1_vld", trap_vld, 1);
    chk("d1_cause", trap_info.cause, 13);
    chk("d1_epc", trap_info.epc, 64'h1000 + 64'd62);
    chk("d1_target", trap_target, 64'h8000_0000);
    trap_rdy = 1'b1;
    cyc(); idle_in();
    chk("d1_idle", busy, 0);

    // Same robIdx on two channels: lower channel wins.
    rob_head = 6'd0;
    report(2, 5, 5);
    report(3, 5, 7);
    cyc(); idle_in();
    rob_head = 6'd5;
    commit_vld = 1'b1;
    cyc(); idle_in();
    chk("d2_tie_cause", trap_info.cause, 5);
    trap_rdy = 1'b1;
    cyc(); idle_in();

    // Older report replaces the held one.
    rob_head = 6'd0;
    report(2, 5, 5);
    cyc(); idle_in();
    report(0, 3, 2);
    cyc(); idle_in();
    rob_head = 6'd3;
    commit_vld = 1'b1;
    cyc(); idle_in();
    chk("d2_repl_cause", trap_info.cause, 2);
    trap_rdy = 1'b1;
    cyc(); idle_in();

    // Flush clears the held entry and drops a younger same-cycle report.
    rob_head = 6'd8;
    report(0, 10, 4);
    cyc(); idle_in();
    chk("d3_held", busy, 1);
    flush = 1'b1;
    flush_robIdx = 6'd9;
    report(1, 12, 6);
    cyc(); idle_in();
    chk("d3_flushed", busy, 0);

    // Interrupt pre-empts an exception at the head, vectored target.
    rob_head = 6'd8;
    report(0, 8, 2);
    cyc(); idle_in();
    mtvec      = 64'h8000_0001;
    commit_vld = 1'b1;
    commit_pc  = 64'h1234;
    irq_pend   = 16'h0880;
    irq_en     = 1'b1;
    cyc(); idle_in();
    chk("d4_vld", trap_vld, 1);
    chk("d4_is_irq", trap_is_irq, 1);
    chk("d4_cause", trap_info.cause, 11);
    chk("d4_target", trap_target, 64'h8000_002C);
    chk("d4_epc", trap_info.epc, 64'h1234);
    chk("d4_tval", trap_info.tval, 0);
    trap_rdy = 1'b1;
    cyc(); idle_in();
    chk("d4_discarded", busy, 0);

    // FIRE stalls on rdy=0 and ignores reports and interrupts.
    mtvec    = 64'h8000_0000;
    rob_head = 6'd20;
    report(0, 20, 1);
    cyc(); idle_in();
    commit_vld = 1'b1;
    cyc(); idle_in();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < CH; c++) report(c, 20, 3 + c);
      irq_pend   = 16'hFFFF;
      irq_en     = 1'b1;
      commit_vld = 1'b1;
      cyc();
      chk("d5_vld", trap_vld, 1);
      chk("d5_cause", trap_info.cause, 1);
      chk("d5_block", commit_block, 1);
    end
    idle_in();
    trap_rdy = 1'b1;
    cyc(); idle_in();
    chk("d5_idle", busy, 0);

    // Asynchronous reset in the middle of FIRE.
    report(0, 20, 9);
    cyc(); idle_in();
    commit_vld = 1'b1;
    cyc(); idle_in();
    chk("d6_fire", trap_vld, 1);
    #1 rst = 1'b0;
    #1;
    chk("d6_async_vld", trap_vld, 0);
    chk("d6_async_busy", busy, 0);
    chk("d6_async_target", trap_target, 0);
    @(posedge clk); #1 rst = 1'b1;
    cyc();
    chk("d6_after_busy", busy, 0);
    chk("d6_after_vld", trap_vld, 0);

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) rob_head = rob_head + robIdx_t'($urandom_range(1, 3));
      for (int c = 0; c < CH; c++) begin
        exc_vld[c]        = ($urandom_range(0, 3) == 0);
        exc_robIdx[c]     = ($urandom_range(0, 7) == 0) ? robIdx_t'($urandom_range(0, RS - 1))
                                                        : rob_head + robIdx_t'($urandom_range(0, 6));
        exc_info[c].cause = 6'($urandom);
        exc_info[c].epc   = {$urandom, $urandom};
        exc_info[c].tval  = {$urandom, $urandom};
      end
      flush        = ($urandom_range(0, 9) == 0);
      flush_robIdx = rob_head + robIdx_t'($urandom_range(0, 6));
      commit_vld   = ($urandom_range(0, 2) == 0);
      commit_pc    = {$urandom, $urandom};
      irq_en       = ($urandom_range(0, 3) == 0);
      irq_pend     = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
      mtvec        = {$urandom, $urandom};
      trap_rdy     = 1'($urandom_range(0, 1));
      cyc();
    end
    idle_in();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
Name: trap_arbiter

Overview:
- Collects synchronous exceptions reported by CHANNELS execution/LSU ports and keeps only the oldest one, ordered by ROB age relative to the ROB head.
- Blocks retirement of the faulting instruction when it reaches the head and merges pending interrupts at the commit boundary.
- Emits one registered trap request carrying trapInfo_t, an interrupt flag and the mtvec-derived target PC over a valid/ready handshake.
- Sits between the execute/LSU writeback ports, the ROB commit stage and the CSR/redirect logic.

Parameters:
- CHANNELS, 4, number of exception report ports; must be ≥1.
- ROB_SIZE, `ROB_SIZE, ROB depth; must be a power of two; sets the width of robIdx_t.
- XLEN, 64, width of PC, tval and mtvec; matches `XDEF.
- VEC_EN, 1, 1 = honour mtvec vectored mode; 0 = always use direct mode.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- i_rob_head  in  robIdx_t  current ROB head index.
- i_exc_vld  in  CHANNELS  per-channel exception valid.
- i_exc_robIdx  in  CHANNELS x robIdx_t  faulting instruction ROB index.
- i_exc_info  in  CHANNELS x trapInfo_t  cause/epc/tval.
- i_flush  in  1  squash request.
- i_flush_robIdx  in  robIdx_t  youngest surviving ROB index of the squash.
- i_commit_vld  in  1  ROB head is attempting to retire this cycle.
- i_commit_pc  in  XLEN  PC of the head instruction.
- o_commit_block  out  1  head must not retire.
- i_irq_pend  in  16  mip & mie, bit n = interrupt cause n.
- i_irq_en  in  1  global interrupt enable (mstatus.MIE, or mode-gated equivalent).
- i_mtvec  in  XLEN  mtvec CSR value.
- o_trap_vld  out  1  trap request valid.
- i_trap_rdy  in  1  redirect/CSR accepts the trap.
- o_trap_info  out  trapInfo_t  trap cause, epc and tval.
- o_trap_is_irq  out  1  1 = interrupt, 0 = exception.
- o_trap_target  out  XLEN  handler PC.
- o_busy  out  1  an exception is held or a trap request is pending.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE; held entry invalid.
  - o_trap_vld=0, o_commit_block=0, o_busy=0, o_trap_is_irq=0.
  - o_trap_info=0, o_trap_target=0.
- Age: age(x) = (x - i_rob_head) mod ROB_SIZE; smaller age is older. Wrap-around is handled by this modular subtraction only; raw index comparison is never used.
- FSM states: IDLE (nothing held), HELD (one exception stored), FIRE (o_trap_vld=1).
- Report selection, IDLE and HELD only:
  - Among valid channels, pick the minimum age.
  - Ties (same robIdx) resolve to the lowest channel index.
  - The winner replaces the held entry only if none is held or the winner is strictly older.
  - Storage is registered: a report in cycle t is visible as held in cycle t+1.
- Flush, IDLE and HELD:
  - The held entry is cleared if age(held) > age(i_flush_robIdx).
  - Same-cycle reports with age > age(i_flush_robIdx) are discarded before selection.
  - Flush has priority over report capture. Flush is ignored in FIRE.
- o_commit_block (combinational):
  - Asserted in HELD when held robIdx == i_rob_head.
  - Asserted throughout FIRE.
- Commit boundary, evaluated when i_commit_vld=1:
  - Interrupt taken if i_irq_en && |i_irq_pend.
    - Priority order: 11 > 3 > 7 > 9 > 1 > 5. Other bits are ignored.
    - epc = i_commit_pc; tval = 0; is_irq = 1.
    - Any held exception is discarded; the head re-executes after the handler.
    - The interrupt also pre-empts an exception at the head.
  - Otherwise, if HELD and held robIdx == i_rob_head, the held exception fires (is_irq = 0).
  - Either case moves to FIRE in the next cycle, with registered o_trap_* outputs. Latency is 1 cycle from the commit cycle to o_trap_vld.
- Target computation:
  - base = {i_mtvec[XLEN-1:2], 2'b00}.
  - If VEC_EN and i_mtvec[1:0]==1 and is_irq: target = base + 4*cause.
  - Otherwise target = base. mtvec modes 2 and 3 are treated as direct.
- FIRE:
  - Outputs are held stable until i_trap_rdy=1. The handshake is the cycle with o_trap_vld && i_trap_rdy.
  - The next cycle is IDLE with the held entry cleared.
  - New reports and interrupts are ignored while in FIRE.
- Reset asserted in any state, including mid-FIRE: immediate return to IDLE. No trap is replayed.
- o_busy = (state != IDLE).

Decomposition:
- Shared package (core_define), additions:
  - trapArbState_e {IDLE, HELD, FIRE}.
  - MTVEC_DIRECT=0, MTVEC_VECTORED=1 constants.
  - Interrupt priority list constant.
- trapInfo_t, robIdx_t and rv_trap_t are reused unchanged.
- One sub-module, trap_age_select: a combinational CHANNELS-way oldest-by-age reducer with lowest-index tie-break. It outputs valid, index and robIdx.

Test Plan:
- Head=60, ROB_SIZE=64; ch0 robIdx=2 and ch1 robIdx=62 valid in the same cycle -> ch1 held (age 2 < 6). Commit at head=62 -> o_trap_vld next cycle, cause = ch1 cause, target = base.
- ch2 and ch3 both report robIdx=5 with causes 5 and 7 -> ch2 (cause 5) held. A later report at robIdx=3 (head=0) replaces it.
- Held robIdx=10, head=8; flush with flush_robIdx=9 -> entry cleared, o_busy=0. A same-cycle report at robIdx=12 is dropped.
- Exception held at head; commit with i_irq_pend bits 7 and 11 set, i_irq_en=1, mtvec=0x8000_0001 -> is_irq=1, cause=11, target=0x8000_002C, epc = commit_pc, held exception discarded.
- FIRE with i_trap_rdy=0 for 3 cycles plus new reports -> outputs stable, o_commit_block=1, reports ignored. rdy=1 -> IDLE next cycle.
- Assert rst mid-FIRE -> o_trap_vld falls immediately (async). After release: IDLE, o_busy=0.
